// File: rtl/cpu_axi_arbiter_pkg.sv
// rtl/cpu_axi_arbiter_pkg.sv - shared FSM encoding and AXI-Lite constants for the CPU bus arbiter
package cpu_axi_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/cpu_axi_arbiter.sv
// rtl/cpu_axi_arbiter.sv - shares one AXI4-Lite master between the IF and MEM pipeline ports
module cpu_axi_arbiter
  import cpu_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_ack,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_ack,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_err,
  output logic                stallreq_if,
  output logic                stallreq_mem,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t          state, state_n;
  logic                owner_data_q, owner_data_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [STRB_W-1:0]   wstrb_q, wstrb_n;
  logic                err_q, err_n;
  logic                aw_done_q, aw_done_n;
  logic                w_done_q, w_done_n;
  logic                arvalid_q, arvalid_n;
  logic                rready_q, rready_n;
  logic                awvalid_q, awvalid_n;
  logic                wvalid_q, wvalid_n;
  logic                bready_q, bready_n;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_n;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_n;

  // Channel valids/readies are computed one cycle ahead so the AXI side is fully registered.
  always_comb begin
    state_n      = state;
    owner_data_n = owner_data_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    wstrb_n      = wstrb_q;
    err_n        = err_q;
    aw_done_n    = aw_done_q;
    w_done_n     = w_done_q;
    arvalid_n    = arvalid_q;
    rready_n     = rready_q;
    awvalid_n    = awvalid_q;
    wvalid_n     = wvalid_q;
    bready_n     = bready_q;
    inst_rdata_n = inst_rdata_q;
    data_rdata_n = data_rdata_q;

    case (state)
      ST_IDLE: begin
        // MEM holds the older instruction, so it wins a simultaneous request.
        if (data_req) begin
          owner_data_n = 1'b1;
          addr_n       = data_addr;
          wdata_n      = data_wdata;
          wstrb_n      = data_wstrb;
          err_n        = 1'b0;
          if (data_we) begin
            state_n   = ST_WR;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
          end else begin
            state_n   = ST_RD_ADDR;
            arvalid_n = 1'b1;
          end
        end else if (inst_req) begin
          owner_data_n = 1'b0;
          addr_n       = inst_addr;
          wdata_n      = '0;
          wstrb_n      = '0;
          err_n        = 1'b0;
          state_n      = ST_RD_ADDR;
          arvalid_n    = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (m_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_rvalid) begin
          rready_n = 1'b0;
          err_n    = resp_is_err(m_rresp);
          if (owner_data_q) data_rdata_n = m_rdata;
          else              inst_rdata_n = m_rdata;
          state_n  = ST_DONE;
        end
      end
      ST_WR: begin
        if (awvalid_q && m_awready) begin
          aw_done_n = 1'b1;
          awvalid_n = 1'b0;
        end
        if (wvalid_q && m_wready) begin
          w_done_n = 1'b1;
          wvalid_n = 1'b0;
        end
        if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
          state_n  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_bvalid) begin
          bready_n = 1'b0;
          err_n    = resp_is_err(m_bresp);
          state_n  = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner_data_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state        <= state_n;
      owner_data_q <= owner_data_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      wstrb_q      <= wstrb_n;
      err_q        <= err_n;
      aw_done_q    <= aw_done_n;
      w_done_q     <= w_done_n;
      arvalid_q    <= arvalid_n;
      rready_q     <= rready_n;
      awvalid_q    <= awvalid_n;
      wvalid_q     <= wvalid_n;
      bready_q     <= bready_n;
      inst_rdata_q <= inst_rdata_n;
      data_rdata_q <= data_rdata_n;
    end
  end

  assign inst_ack     = (state == ST_DONE) && !owner_data_q;
  assign data_ack     = (state == ST_DONE) && owner_data_q;
  assign bus_err      = (state == ST_DONE) && err_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign stallreq_if  = inst_req & ~inst_ack;
  assign stallreq_mem = data_req & ~data_ack;

  assign m_arvalid = arvalid_q;
  assign m_araddr  = addr_q;
  assign m_arprot  = AXI_PROT_DEFAULT;
  assign m_rready  = rready_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_awprot  = AXI_PROT_DEFAULT;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = bready_q;

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// tb/tb_cpu_axi_arbiter.sv - self-checking bench: AXI-Lite slave model plus word-level reference memory
module tb_cpu_axi_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, inst_ack;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_we, data_ack;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        bus_err, stallreq_if, stallreq_mem;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [2:0]  m_arprot, m_awprot;
  logic [1:0]  m_rresp, m_bresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;

  cpu_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_ack(data_ack), .data_rdata(data_rdata),
    .bus_err(bus_err), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h2408_0001 + 32'(i) * 32'h0101_0000;
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return a[31:28] == 4'hE;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Slave: knobs from the stimulus block gate the registered readies and hold back read data.
  logic rand_mode = 1'b0, ar_hold = 1'b0, aw_hold = 1'b0, w_hold = 1'b0, r_hold = 1'b0;
  logic arready_r, awready_r, wready_r, r_pend, r_err, aw_got, w_got;
  logic [1:0]  r_cnt, b_cnt, draw;
  logic [7:0]  r_idx;
  logic [31:0] aw_a, w_d;
  logic [3:0]  w_s;
  logic [31:0] slv_mem [256];

  assign m_arready = arready_r & ~ar_hold;
  assign m_awready = awready_r & ~aw_hold;
  assign m_wready  = wready_r & ~w_hold;

  always @(posedge clk) begin
    if (rst) begin
      arready_r <= 1'b0; awready_r <= 1'b0; wready_r <= 1'b0;
      r_pend <= 1'b0; r_err <= 1'b0; r_cnt <= '0; r_idx <= '0; draw <= '0;
      m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; w_s <= '0; b_cnt <= '0;
      m_bvalid <= 1'b0; m_bresp <= '0;
      for (int i = 0; i < 256; i++) slv_mem[i] <= init_word(i);
    end else begin
      arready_r <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      awready_r <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      wready_r  <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      draw      <= rand_mode ? 2'($urandom_range(0, 3)) : 2'd0;
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        if (draw == 2'd0 && !r_hold) begin
          m_rvalid <= 1'b1;
          m_rdata  <= slv_mem[m_araddr[9:2]];
          m_rresp  <= is_err(m_araddr) ? 2'b10 : 2'b00;
        end else begin
          r_pend <= 1'b1; r_cnt <= draw; r_idx <= m_araddr[9:2]; r_err <= is_err(m_araddr);
        end
      end
      if (r_pend && !r_hold) begin
        if (r_cnt == 2'd0) begin
          m_rvalid <= 1'b1; m_rdata <= slv_mem[r_idx]; m_rresp <= r_err ? 2'b10 : 2'b00; r_pend <= 1'b0;
        end else r_cnt <= r_cnt - 2'd1;
      end
      if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_a <= m_awaddr; end
      if (m_wvalid && m_wready) begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (aw_got && w_got && !m_bvalid) begin
        if (b_cnt == 2'd0) begin
          m_bvalid <= 1'b1;
          m_bresp  <= is_err(aw_a) ? 2'b10 : 2'b00;
          if (!is_err(aw_a)) slv_mem[aw_a[9:2]] <= merge(slv_mem[aw_a[9:2]], w_d, w_s);
          aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= draw;
        end else b_cnt <= b_cnt - 2'd1;
      end
    end
  end

  // Valid/payload must not change or drop while the slave withholds ready.
  int stab_viol = 0;
  int cyc = 0;
  logic p_rst = 1'b1, p_arv = 1'b0, p_awv = 1'b0, p_wv = 1'b0;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [3:0]  p_wstrb;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && !p_rst) begin
      if (p_arv && (!m_arvalid || m_araddr !== p_araddr)) stab_viol <= stab_viol + 1;
      if (p_awv && (!m_awvalid || m_awaddr !== p_awaddr)) stab_viol <= stab_viol + 1;
      if (p_wv && (!m_wvalid || m_wdata !== p_wdata || m_wstrb !== p_wstrb)) stab_viol <= stab_viol + 1;
    end
    p_rst <= rst;
    p_arv <= m_arvalid & ~m_arready; p_araddr <= m_araddr;
    p_awv <= m_awvalid & ~m_awready; p_awaddr <= m_awaddr;
    p_wv  <= m_wvalid & ~m_wready;   p_wdata <= m_wdata; p_wstrb <= m_wstrb;
  end

  int n_checks = 0, n_errors = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] tr_inst_rdata, tr_data_rdata;
  logic        e_i_on, e_d_on, e_d_we;
  logic [31:0] e_i_addr, e_d_addr, e_d_wdata;
  logic [3:0]  e_d_wstrb;
  int start_cyc, last_i_cyc, last_d_cyc, stall_high;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_init();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    tr_inst_rdata = '0;
    tr_data_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_init();
  endtask

  // Call just after a negedge: drives the requests for cycle N.
  task automatic start_pair(input logic i_on, input logic [31:0] i_addr, input logic d_on,
                            input logic d_we, input logic [31:0] d_addr, input logic [31:0] d_wdata,
                            input logic [3:0] d_wstrb);
    e_i_on = i_on; e_i_addr = i_addr; e_d_on = d_on; e_d_we = d_we;
    e_d_addr = d_addr; e_d_wdata = d_wdata; e_d_wstrb = d_wstrb;
    inst_req = i_on; inst_addr = i_addr;
    data_req = d_on; data_we = d_we; data_addr = d_addr; data_wdata = d_wdata; data_wstrb = d_wstrb;
    start_cyc = cyc;
    stall_high = 0;
    #1;
    if (stallreq_if) stall_high++;
  endtask

  task automatic finish_pair();
    int budget = 300;
    int d_acks = 0, i_acks = 0, bad_stall = 0, stray_err = 0;
    logic d_done = !e_d_on, i_done = !e_i_on;
    while (!(d_done && i_done) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (stallreq_if !== (inst_req & ~inst_ack) || stallreq_mem !== (data_req & ~data_ack)) bad_stall++;
      if (stallreq_if) stall_high++;
      if (bus_err && !inst_ack && !data_ack) stray_err++;
      if (data_ack) begin
        d_acks++; last_d_cyc = cyc;
        if (!e_d_we) tr_data_rdata = ref_mem[e_d_addr[9:2]];
        else if (!is_err(e_d_addr)) ref_mem[e_d_addr[9:2]] = merge(ref_mem[e_d_addr[9:2]], e_d_wdata, e_d_wstrb);
        check("data_rdata", data_rdata, tr_data_rdata);
        check("data_bus_err", bus_err, is_err(e_d_addr));
        check("inst_rdata_hold", inst_rdata, tr_inst_rdata);
        data_req = 1'b0; d_done = 1'b1;
      end
      if (inst_ack) begin
        i_acks++; last_i_cyc = cyc;
        tr_inst_rdata = ref_mem[e_i_addr[9:2]];
        check("inst_rdata", inst_rdata, tr_inst_rdata);
        check("inst_bus_err", bus_err, is_err(e_i_addr));
        check("data_rdata_hold", data_rdata, tr_data_rdata);
        check("data_before_inst", d_acks, e_d_on ? 1 : 0);
        inst_req = 1'b0; i_done = 1'b1;
      end
    end
    if (!(d_done && i_done)) begin
      check("ack_timeout", 0, 1);
      do_reset();
    end else begin
      repeat (3) begin
        @(negedge clk);
        if (data_ack) d_acks++;
        if (inst_ack) i_acks++;
        if (bus_err) stray_err++;
      end
      check("data_ack_count", d_acks, e_d_on ? 1 : 0);
      check("inst_ack_count", i_acks, e_i_on ? 1 : 0);
      check("stall_outputs", bad_stall, 0);
      check("stray_bus_err", stray_err, 0);
    end
  endtask

  logic        r_i_on, r_d_on, r_we;
  logic [31:0] r_i_addr, r_d_addr;
  int          ack_cnt;

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_we = 1'b0;
    data_addr = '0; data_wdata = '0; data_wstrb = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, inst_ack, data_ack, bus_err}, 0);
    check("reset_rdata", inst_rdata | data_rdata, 0);
    check("reset_prot_stall", {m_arprot, m_awprot, stallreq_if, stallreq_mem}, 0);
    rst = 1'b0;
    ref_init();
    @(negedge clk);

    // Zero-wait instruction read: ack three cycles after the grant cycle.
    start_pair(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, '0, '0, '0);
    finish_pair();
    check("inst_read_latency", last_i_cyc - start_cyc, 3);
    check("inst_stall_cycles", stall_high, 3);
    check("inst_read_value", inst_rdata, 32'h2408_0001);

    // Zero-wait write: one extra cycle for the response channel.
    start_pair(1'b0, '0, 1'b1, 1'b1, 32'h8000_0018, 32'h1234_5678, 4'b1111);
    finish_pair();
    check("write_latency", last_d_cyc - start_cyc, 4);

    // Write with awready two cycles ahead of wready.
    aw_hold = 1'b1; w_hold = 1'b1;
    start_pair(1'b0, '0, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011);
    @(negedge clk);
    check("wr_valids_together", {m_awvalid, m_wvalid}, 2'b11);
    check("wr_awaddr", m_awaddr, 32'h8000_0010);
    aw_hold = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("wr_aw_done_w_held", {m_awvalid, m_wvalid}, 2'b01);
      check("wr_wdata_stable", m_wdata, 32'hDEAD_BEEF);
      check("wr_wstrb_stable", m_wstrb, 4'b0011);
    end
    w_hold = 1'b0;
    finish_pair();

    // Simultaneous reads: data first, inst granted in the IDLE cycle after data's DONE.
    start_pair(1'b1, 32'h8000_0004, 1'b1, 1'b0, 32'h8000_0010, '0, '0);
    finish_pair();
    check("inst_after_data_gap", last_i_cyc - last_d_cyc, 4);
    check("merged_write_readback", data_rdata, merge(init_word(4), 32'hDEAD_BEEF, 4'b0011));

    // Error response on a data read.
    start_pair(1'b0, '0, 1'b1, 1'b0, 32'hE000_0040, '0, '0);
    finish_pair();

    // Read-address back-pressure for five cycles.
    ar_hold = 1'b1;
    start_pair(1'b0, '0, 1'b1, 1'b0, 32'h8000_000C, '0, '0);
    repeat (5) begin
      @(negedge clk);
      check("bp_arvalid", m_arvalid, 1'b1);
      check("bp_araddr", m_araddr, 32'h8000_000C);
      check("bp_stallreq_mem", stallreq_mem, 1'b1);
    end
    ar_hold = 1'b0;
    finish_pair();

    // Reset while waiting for read data.
    r_hold = 1'b1;
    start_pair(1'b0, '0, 1'b1, 1'b0, 32'h8000_0014, '0, '0);
    for (int k = 0; k < 10 && !m_rready; k++) @(negedge clk);
    check("reached_rd_data", m_rready, 1'b1);
    rst = 1'b1; data_req = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, inst_ack, data_ack, bus_err}, 0);
    check("rst_mid_rdata", data_rdata, 0);
    rst = 1'b0; r_hold = 1'b0;
    ref_init();
    ack_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (inst_ack || data_ack) ack_cnt++;
    end
    check("rst_mid_no_ack", ack_cnt, 0);
    start_pair(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, '0, '0, '0);
    finish_pair();
    check("post_rst_latency", last_i_cyc - start_cyc, 3);

    // Randomized traffic with random slave wait states.
    rand_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      r_i_on = 1'($urandom_range(0, 1));
      r_d_on = 1'($urandom_range(0, 1));
      if (!r_i_on && !r_d_on) r_d_on = 1'b1;
      r_we = 1'($urandom_range(0, 1));
      r_i_addr = {($urandom_range(0, 5) == 0) ? 4'hE : 4'h8, 18'h0, 8'($urandom_range(0, 15)), 2'b00};
      r_d_addr = {($urandom_range(0, 5) == 0) ? 4'hE : 4'h8, 18'h0, 8'($urandom_range(0, 15)), 2'b00};
      start_pair(r_i_on, r_i_addr, r_d_on, r_we, r_d_addr, $urandom, 4'($urandom_range(0, 15)));
      finish_pair();
    end

    check("axi_stability", stab_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
